// File: rtl/alu.sv
// Signed W-bit ALU with a registered result accumulator and registered Z/N/C/V flags.
// One operation is accepted per clock; results and flags appear one cycle after sampling.
module alu #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);

    typedef enum logic [4:0] {
        OP_NOP = 5'b00000,
        OP_ADD = 5'b00001,
        OP_SUB = 5'b00010,
        OP_MUL = 5'b00011,
        OP_DIV = 5'b00100,
        OP_MOD = 5'b00101,
        OP_AND = 5'b00110,
        OP_OR  = 5'b00111,
        OP_XOR = 5'b01000,
        OP_NOT = 5'b01001,
        OP_LSL = 5'b01010,
        OP_LSR = 5'b01011,
        OP_ASR = 5'b01100,
        OP_ROL = 5'b01101,
        OP_ROR = 5'b01110,
        OP_CMP = 5'b01111,
        OP_TST = 5'b10000,
        OP_INC = 5'b10001,
        OP_DEC = 5'b10010,
        OP_MOV = 5'b10011,
        OP_NEG = 5'b10100
    } alu_op_e;

    localparam logic [W-1:0] WIDTH_V  = W'(W);
    localparam logic [W-1:0] ZERO_V   = {W{1'b0}};
    localparam logic [W-1:0] ONE_V    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ONES_V   = {W{1'b1}};
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    // Pack {Z, N, C, V} from a W-bit value and the op-specific carry/overflow.
    function automatic logic [3:0] flags_of(input logic [W-1:0] value, input logic c, input logic v);
        flags_of = {(value == ZERO_V), value[W-1], c, v};
    endfunction

    logic [W-1:0]          result_r;
    logic [3:0]            flags_r;
    logic [W-1:0]          next_result_s;
    logic [3:0]            next_flags_s;

    logic [W-1:0]          add_b_s;
    logic [W-1:0]          sub_a_s;
    logic [W-1:0]          sub_b_s;
    logic [W:0]            add_s;
    logic [W:0]            sub_s;
    logic                  add_v_s;
    logic                  sub_v_s;

    logic signed [2*W-1:0] prod_s;
    logic                  mul_ovf_s;

    logic                  div_zero_s;
    logic                  div_ovf_s;
    logic [W-1:0]          div_b_s;
    logic signed [W-1:0]   quot_s;
    logic signed [W-1:0]   rem_s;

    logic                  shift_big_s;
    logic [W:0]            lsl_s;
    logic [W:0]            lsr_s;
    logic signed [W:0]     asr_s;
    logic [W-1:0]          rot_amt_s;
    logic [W-1:0]          rol_s;
    logic [W-1:0]          ror_s;

    // Adder/subtractor operand selection shared by ADD/INC and SUB/CMP/DEC/NEG.
    always_comb begin
        add_b_s = operandB;
        sub_a_s = operandA;
        sub_b_s = operandB;
        if (alu_op == OP_INC) begin
            add_b_s = ONE_V;
        end else begin
            add_b_s = operandB;
        end
        case (alu_op)
            OP_DEC: begin
                sub_a_s = operandA;
                sub_b_s = ONE_V;
            end
            OP_NEG: begin
                sub_a_s = ZERO_V;
                sub_b_s = operandA;
            end
            default: begin
                sub_a_s = operandA;
                sub_b_s = operandB;
            end
        endcase
    end

    // The extra MSB of add_s is the carry-out; of sub_s, the unsigned borrow.
    assign add_s   = {1'b0, operandA} + {1'b0, add_b_s};
    assign sub_s   = {1'b0, sub_a_s} - {1'b0, sub_b_s};
    assign add_v_s = (operandA[W-1] == add_b_s[W-1]) && (add_s[W-1] != operandA[W-1]);
    assign sub_v_s = (sub_a_s[W-1] != sub_b_s[W-1]) && (sub_s[W-1] != sub_a_s[W-1]);

    assign prod_s    = $signed({{W{operandA[W-1]}}, operandA}) * $signed({{W{operandB[W-1]}}, operandB});
    assign mul_ovf_s = !((&prod_s[2*W-1:W-1]) || !(|prod_s[2*W-1:W-1]));

    // Divide-by-zero and MIN/-1 are handled explicitly, so the divider always sees a safe divisor.
    assign div_zero_s = (operandB == ZERO_V);
    assign div_ovf_s  = (operandA == MIN_NEG) && (operandB == ONES_V);
    assign div_b_s    = (div_zero_s || div_ovf_s) ? ONE_V : operandB;
    assign quot_s     = $signed(operandA) / $signed(div_b_s);
    assign rem_s      = $signed(operandA) % $signed(div_b_s);

    // One guard bit on each shifter captures the last bit shifted out.
    assign shift_big_s = (operandB >= WIDTH_V);
    assign lsl_s       = {1'b0, operandA} << operandB;
    assign lsr_s       = {operandA, 1'b0} >> operandB;
    assign asr_s       = $signed({operandA, 1'b0}) >>> operandB;
    assign rot_amt_s   = operandB % WIDTH_V;
    assign rol_s       = (operandA << rot_amt_s) | (operandA >> (WIDTH_V - rot_amt_s));
    assign ror_s       = (operandA >> rot_amt_s) | (operandA << (WIDTH_V - rot_amt_s));

    // Next-state selection; anything not written holds its current value.
    always_comb begin
        next_result_s = result_r;
        next_flags_s  = flags_r;
        case (alu_op)
            OP_ADD, OP_INC: begin
                next_result_s = add_s[W-1:0];
                next_flags_s  = flags_of(add_s[W-1:0], add_s[W], add_v_s);
            end
            OP_SUB, OP_DEC, OP_NEG: begin
                next_result_s = sub_s[W-1:0];
                next_flags_s  = flags_of(sub_s[W-1:0], sub_s[W], sub_v_s);
            end
            OP_CMP: begin
                next_flags_s = flags_of(sub_s[W-1:0], sub_s[W], sub_v_s);
            end
            OP_MUL: begin
                next_result_s = prod_s[W-1:0];
                next_flags_s  = flags_of(prod_s[W-1:0], mul_ovf_s, mul_ovf_s);
            end
            OP_DIV: begin
                if (div_zero_s) begin
                    next_result_s = ZERO_V;
                    next_flags_s  = 4'b1001;
                end else if (div_ovf_s) begin
                    next_result_s = MIN_NEG;
                    next_flags_s  = flags_of(MIN_NEG, 1'b0, 1'b1);
                end else begin
                    next_result_s = quot_s;
                    next_flags_s  = flags_of(quot_s, 1'b0, 1'b0);
                end
            end
            OP_MOD: begin
                if (div_zero_s) begin
                    next_result_s = ZERO_V;
                    next_flags_s  = 4'b1001;
                end else begin
                    next_result_s = rem_s;
                    next_flags_s  = flags_of(rem_s, 1'b0, 1'b0);
                end
            end
            OP_AND: begin
                next_result_s = operandA & operandB;
                next_flags_s  = flags_of(operandA & operandB, 1'b0, 1'b0);
            end
            OP_OR: begin
                next_result_s = operandA | operandB;
                next_flags_s  = flags_of(operandA | operandB, 1'b0, 1'b0);
            end
            OP_XOR: begin
                next_result_s = operandA ^ operandB;
                next_flags_s  = flags_of(operandA ^ operandB, 1'b0, 1'b0);
            end
            OP_NOT: begin
                next_result_s = ~operandA;
                next_flags_s  = flags_of(~operandA, 1'b0, 1'b0);
            end
            OP_TST: begin
                next_flags_s = flags_of(operandA & operandB, 1'b0, 1'b0);
            end
            OP_MOV: begin
                next_result_s = operandB;
                next_flags_s  = flags_of(operandB, 1'b0, 1'b0);
            end
            OP_LSL: begin
                if (operandB == ZERO_V) begin
                    next_result_s = operandA;
                    next_flags_s  = flags_of(operandA, 1'b0, 1'b0);
                end else if (shift_big_s) begin
                    next_result_s = ZERO_V;
                    next_flags_s  = flags_of(ZERO_V, 1'b0, 1'b0);
                end else begin
                    next_result_s = lsl_s[W-1:0];
                    next_flags_s  = flags_of(lsl_s[W-1:0], lsl_s[W], 1'b0);
                end
            end
            OP_LSR: begin
                if (operandB == ZERO_V) begin
                    next_result_s = operandA;
                    next_flags_s  = flags_of(operandA, 1'b0, 1'b0);
                end else if (shift_big_s) begin
                    next_result_s = ZERO_V;
                    next_flags_s  = flags_of(ZERO_V, 1'b0, 1'b0);
                end else begin
                    next_result_s = lsr_s[W:1];
                    next_flags_s  = flags_of(lsr_s[W:1], lsr_s[0], 1'b0);
                end
            end
            OP_ASR: begin
                if (operandB == ZERO_V) begin
                    next_result_s = operandA;
                    next_flags_s  = flags_of(operandA, 1'b0, 1'b0);
                end else if (shift_big_s) begin
                    next_result_s = {W{operandA[W-1]}};
                    next_flags_s  = flags_of({W{operandA[W-1]}}, operandA[W-1], 1'b0);
                end else begin
                    next_result_s = asr_s[W:1];
                    next_flags_s  = flags_of(asr_s[W:1], asr_s[0], 1'b0);
                end
            end
            OP_ROL: begin
                if (rot_amt_s == ZERO_V) begin
                    next_result_s = operandA;
                    next_flags_s  = flags_of(operandA, 1'b0, 1'b0);
                end else begin
                    next_result_s = rol_s;
                    next_flags_s  = flags_of(rol_s, rol_s[0], 1'b0);
                end
            end
            OP_ROR: begin
                if (rot_amt_s == ZERO_V) begin
                    next_result_s = operandA;
                    next_flags_s  = flags_of(operandA, 1'b0, 1'b0);
                end else begin
                    next_result_s = ror_s;
                    next_flags_s  = flags_of(ror_s, ror_s[W-1], 1'b0);
                end
            end
            default: begin
                next_result_s = result_r;
                next_flags_s  = flags_r;
            end
        endcase
    end

    // Accumulator and flag registers; reset wins over any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= ZERO_V;
            flags_r  <= 4'b0000;
        end else begin
            result_r <= next_result_s;
            flags_r  <= next_flags_s;
        end
    end

    assign resultAccumulator = result_r;
    assign flags             = flags_r;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (W=16): hand-computed result/flag vectors,
// one op per clock, outputs sampled 1 time unit after the rising edge.
module tb_alu;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [4:0]   alu_op;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [W-1:0] resultAccumulator;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    alu #(.W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_op            (alu_op),
        .operandA          (operandA),
        .operandB          (operandB),
        .resultAccumulator (resultAccumulator),
        .flags             (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic r,
                        input logic [W-1:0] exp_r, input logic [3:0] exp_f);
        @(negedge clk);
        alu_op   = op;
        operandA = a;
        operandB = b;
        rst      = r;
        @(posedge clk);
        #1;
        check({tag, ".R"}, resultAccumulator, exp_r);
        check({tag, ".F"}, {12'h000, flags}, {12'h000, exp_f});
    endtask

    initial begin
        rst      = 1'b1;
        alu_op   = 5'b00001;
        operandA = 16'h1111;
        operandB = 16'h2222;
        repeat (2) @(posedge clk);
        #1;
        check("reset.R", resultAccumulator, 16'h0000);
        check("reset.F", {12'h000, flags}, 16'h0000);

        //    tag          op        A         B         rst   R         ZNCV
        step("add_pos",   5'b00001, 16'd10,   16'd5,    1'b0, 16'd15,   4'b0000);
        step("add_neg",   5'b00001, 16'hFFF3, 16'hFFF9, 1'b0, 16'hFFEC, 4'b0110);
        step("add_mix1",  5'b00001, 16'd1,    16'hFFF7, 1'b0, 16'hFFF8, 4'b0100);
        step("add_mix2",  5'b00001, 16'd3,    16'hFFF9, 1'b0, 16'hFFFC, 4'b0100);
        step("add_ovf",   5'b00001, 16'h7FFF, 16'd1,    1'b0, 16'h8000, 4'b0101);
        step("sub_zero",  5'b00010, 16'd5,    16'd5,    1'b0, 16'h0000, 4'b1000);
        step("div_zero",  5'b00100, 16'd7,    16'd0,    1'b0, 16'h0000, 4'b1001);
        step("cmp",       5'b01111, 16'd3,    16'd7,    1'b0, 16'h0000, 4'b0110);
        step("lsl1",      5'b01010, 16'h8001, 16'd1,    1'b0, 16'h0002, 4'b0010);
        step("asr_big",   5'b01100, 16'hFFF8, 16'd20,   1'b0, 16'hFFFF, 4'b0110);
        step("rst_add",   5'b00001, 16'd10,   16'd5,    1'b1, 16'h0000, 4'b0000);
        step("nop_rst",   5'b00000, 16'd10,   16'd5,    1'b0, 16'h0000, 4'b0000);
        step("mov",       5'b10011, 16'hAAAA, 16'h1234, 1'b0, 16'h1234, 4'b0000);
        step("nop_hold",  5'b00000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h1234, 4'b0000);
        step("op_1f",     5'b11111, 16'h0001, 16'h0001, 1'b0, 16'h1234, 4'b0000);
        step("op_15",     5'b10101, 16'h0000, 16'h0000, 1'b0, 16'h1234, 4'b0000);
        step("cmp_hold",  5'b01111, 16'd9,    16'd9,    1'b0, 16'h1234, 4'b1000);
        step("mul_ovf",   5'b00011, 16'd300,  16'd300,  1'b0, 16'h5F90, 4'b0011);
        step("mul_neg",   5'b00011, 16'hFFFD, 16'd4,    1'b0, 16'hFFF4, 4'b0100);
        step("div_trunc", 5'b00100, 16'hFFF9, 16'd2,    1'b0, 16'hFFFD, 4'b0100);
        step("mod_sign",  5'b00101, 16'hFFF9, 16'd2,    1'b0, 16'hFFFF, 4'b0100);
        step("mod_zero",  5'b00101, 16'd9,    16'd0,    1'b0, 16'h0000, 4'b1001);
        step("div_minm1", 5'b00100, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 4'b0101);
        step("sub_ovf",   5'b00010, 16'h8000, 16'd1,    1'b0, 16'h7FFF, 4'b0001);
        step("neg_zero",  5'b10100, 16'd0,    16'd0,    1'b0, 16'h0000, 4'b1000);
        step("neg_five",  5'b10100, 16'd5,    16'd0,    1'b0, 16'hFFFB, 4'b0110);
        step("inc_wrap",  5'b10001, 16'hFFFF, 16'd0,    1'b0, 16'h0000, 4'b1010);
        step("dec_wrap",  5'b10010, 16'h0000, 16'd0,    1'b0, 16'hFFFF, 4'b0110);
        step("rol17",     5'b01101, 16'h8001, 16'd17,   1'b0, 16'h0003, 4'b0010);
        step("ror1",      5'b01110, 16'h0001, 16'd1,    1'b0, 16'h8000, 4'b0110);
        step("rol16",     5'b01101, 16'h1234, 16'd16,   1'b0, 16'h1234, 4'b0000);
        step("lsr1",      5'b01011, 16'h0003, 16'd1,    1'b0, 16'h0001, 4'b0010);
        step("lsl16",     5'b01010, 16'hFFFF, 16'd16,   1'b0, 16'h0000, 4'b1000);
        step("lsl0",      5'b01010, 16'h00F0, 16'd0,    1'b0, 16'h00F0, 4'b0000);
        step("tst",       5'b10000, 16'h00F0, 16'h0F00, 1'b0, 16'h00F0, 4'b1000);
        step("xor",       5'b01000, 16'hFFFF, 16'h00FF, 1'b0, 16'hFF00, 4'b0100);
        step("and",       5'b00110, 16'h0F0F, 16'h00FF, 1'b0, 16'h000F, 4'b0000);
        step("or",        5'b00111, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 4'b0000);
        step("not",       5'b01001, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 4'b0100);
        step("asr3",      5'b01100, 16'hFF8C, 16'd3,    1'b0, 16'hFFF1, 4'b0110);
        step("lsr_big",   5'b01011, 16'hFFFF, 16'd40,   1'b0, 16'h0000, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Signed W-bit arithmetic/logic unit with a registered result ("accumulator") and registered status flags.
- Sits in the datapath after the register file.
- Each clock it samples alu_op, operandA and operandB, computes, and updates resultAccumulator and flags.
- Pure-flag operations update flags only. NOP holds all state.

Parameters:
- W, 16, datapath width in bits (W >= 4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- alu_op  input  5  operation select.
- operandA  input  W  signed operand A.
- operandB  input  W  signed operand B.
- resultAccumulator  output  W  signed registered result.
- flags  output  4  registered status: [3]=Z, [2]=N, [1]=C, [0]=V.

Behaviour:
- Reset: on a rising clk with rst=1, resultAccumulator=0 and flags=4'b0000, regardless of alu_op. Reset takes priority over any operation in that cycle.
- Latency: inputs are sampled at a rising edge; the result and flags are valid after that edge, so latency is 1 cycle. No handshake; a new op is accepted every cycle.
- Opcodes (R = new result, A/B = operands):
  - 00000 NOP: hold R and flags.
  - 00001 ADD: A+B.
  - 00010 SUB: A-B.
  - 00011 MUL: low W bits of the signed product.
  - 00100 DIV: signed A/B, truncating toward zero.
  - 00101 MOD: signed remainder; sign follows A.
  - 00110 AND, 00111 OR, 01000 XOR: bitwise.
  - 01001 NOT: ~A.
  - 01010 LSL, 01011 LSR, 01100 ASR: shift A by unsigned B.
  - 01101 ROL, 01110 ROR: rotate A by B mod W.
  - 01111 CMP: flags of A-B; R held.
  - 10000 TST: flags of A&B; R held.
  - 10001 INC: A+1.
  - 10010 DEC: A-1.
  - 10011 MOV: B.
  - 10100 NEG: -A.
  - 10101..11111: treated as NOP.
- Flags are computed on the W-bit result, or on the internal value for CMP/TST:
  - Z = result == 0.
  - N = result MSB.
  - ADD/INC: C = unsigned carry-out of bit W-1. V = signed overflow (operands same sign, result sign differs).
  - SUB/CMP/DEC/NEG: C = unsigned borrow (A < B unsigned; for NEG: A != 0). V = signed overflow of the subtraction.
  - MUL: C = V = 1 when the full 2W-bit signed product does not fit in W signed bits.
  - DIV/MOD with B=0: R=0, Z=1, V=1, C=0.
  - DIV of most-negative by -1: R = most-negative value, V=1.
  - Logic ops, NOT, MOV, TST: C=0, V=0.
- Shifts:
  - Amount B is taken as unsigned.
  - Amount 0: R=A, C=0.
  - Amount >= W: LSL/LSR give 0; ASR gives all copies of the sign bit.
  - C = last bit shifted out; for amount >= W, C = 0 (LSL/LSR) or sign bit (ASR).
  - V = 0.
- Rotates: C = last bit rotated across the end (0 if amount mod W = 0). V = 0.
- Arithmetic wraps modulo 2^W; no saturation.

Test Plan:
- ADD, two positive / two negative operands: A=10, B=5 -> after 1 edge R=15, flags=0000. Then A=-13, B=-7 -> R=-20, flags=0110 (N, C).
- ADD, mixed signs: A=1, B=-9 -> R=-8, flags=0100. Then A=3, B=-7 -> R=-4, flags=0100.
- ADD overflow, then SUB to zero: A=32767, B=1 (W=16) -> R=-32768, flags=0101 (N, V). Then SUB A=5, B=5 -> R=0, flags=1000.
- DIV by zero and CMP: DIV A=7, B=0 -> R=0, flags=1001. Then CMP A=3, B=7 -> R stays 0, flags=0110 (N, borrow).
- Shifts: LSL A=16'h8001, B=1 -> R=16'h0002, C=1. ASR A=-8, B=20 -> R=-1, flags=0110.
- Reset mid-stream: ADD A=10, B=5 with rst=1 on the same edge -> R=0, flags=0000. Then NOP with rst=0 -> R and flags hold.
